// File: rtl/pwm_ramp_sequencer.sv
// Bus-programmed duty ramp for a Pwm2 core, stepped on carry-out; optional PWM_SEQ_IRQ_EN adds a sticky done irq.
// Latency: 1-cycle register read. No backpressure: co pulses pace the ramp and bus accesses always complete.
module pwm_ramp_sequencer #(
    parameter int DW     = 32,
    parameter int AW     = 3,
    parameter int HOLD_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW+1:0] addr,
    input  logic          write,
    input  logic [DW-1:0] wrdata,
    output logic [DW-1:0] rddata,
    input  logic          co,
    output logic [DW-1:0] period,
    output logic [DW-1:0] duty,
    output logic          busy,
    output logic          irq
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [AW-1:0] R_PERIOD = AW'(0);
    localparam logic [AW-1:0] R_START  = AW'(1);
    localparam logic [AW-1:0] R_END    = AW'(2);
    localparam logic [AW-1:0] R_STEP   = AW'(3);
    localparam logic [AW-1:0] R_HOLD   = AW'(4);
    localparam logic [AW-1:0] R_CTRL   = AW'(5);
    localparam logic [AW-1:0] R_STATUS = AW'(6);
    localparam logic [AW-1:0] R_CUR    = AW'(7);
    localparam logic [1:0]    M_LOOP   = 2'd1;
    localparam logic [1:0]    M_TRI    = 2'd2;

    state_t              state_q, state_d;
    logic [DW-1:0]       period_q, period_d, start_q, start_d, endv_q, endv_d;
    logic [DW-1:0]       step_q, step_d, duty_q, duty_d, rddata_q, rddata_d;
    logic [HOLD_W-1:0]   hold_q, hold_d, cnt_q, cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic                dir_q, dir_d, done_q, done_d, back_q, back_d;

    logic [AW-1:0]       wr_idx;
    logic                ctrl_wr, go, stop, adv_tick, addr_unused;
    logic [DW-1:0]       tgt, eff_tgt, up_val, dn_val, step_val;
    logic [DW:0]         sum, diff;
    logic                flip, step_down;

    assign wr_idx      = addr[AW+1:2];
    assign addr_unused = ^addr[1:0];
    assign ctrl_wr     = write && (wr_idx == R_CTRL);
    assign go          = ctrl_wr && wrdata[0] && !wrdata[1];
    assign stop        = ctrl_wr && wrdata[1];
    assign adv_tick    = (state_q == S_RUN) && co && !ctrl_wr;

    // back_q selects the current target: END on the outbound leg, START on the triangle return leg.
    always_comb begin
        tgt     = back_q ? start_q : endv_q;
        flip    = (mode_q == M_TRI) && (duty_q == tgt);
        eff_tgt = flip ? (back_q ? endv_q : start_q) : tgt;
        sum     = {1'b0, duty_q} + {1'b0, step_q};
        diff    = {1'b0, duty_q} - {1'b0, step_q};
        up_val  = (sum > {1'b0, eff_tgt}) ? eff_tgt : sum[DW-1:0];
        dn_val  = (diff[DW] || (diff[DW-1:0] < eff_tgt)) ? eff_tgt : diff[DW-1:0];
        step_val  = duty_q;
        step_down = dir_q;
        if (duty_q < eff_tgt) begin
            step_val  = up_val;
            step_down = 1'b0;
        end else if (duty_q > eff_tgt) begin
            step_val  = dn_val;
            step_down = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        start_d  = start_q;
        endv_d   = endv_q;
        step_d   = step_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        duty_d   = duty_q;
        dir_d    = dir_q;
        done_d   = done_q;
        back_d   = back_q;
        rddata_d = '0;

        if (write) begin
            case (wr_idx)
                R_PERIOD: period_d = wrdata;
                R_START:  start_d  = wrdata;
                R_END:    endv_d   = wrdata;
                R_STEP:   step_d   = wrdata;
                R_HOLD:   hold_d   = wrdata[HOLD_W-1:0];
                R_STATUS: if (wrdata[1]) done_d = 1'b0;
                default:  ;
            endcase
        end

        if (stop) begin
            state_d = S_IDLE;
        end else if (go) begin
            dir_d  = (start_q > endv_q);
            cnt_d  = '0;
            back_d = 1'b0;
            mode_d = wrdata[3:2];
            if ((step_q == '0) || (start_q == endv_q)) begin
                duty_d  = endv_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                duty_d  = start_q;
                done_d  = 1'b0;
                state_d = S_RUN;
            end
        end else if (adv_tick) begin
            if (cnt_q != hold_q) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
                case (mode_q)
                    M_LOOP: begin
                        if (duty_q == endv_q) begin
                            duty_d = start_q;
                            dir_d  = (start_q > endv_q);
                        end else begin
                            duty_d = step_val;
                            dir_d  = step_down;
                        end
                    end
                    M_TRI: begin
                        duty_d = step_val;
                        dir_d  = step_down;
                        back_d = back_q ^ flip;
                    end
                    default: begin
                        duty_d = step_val;
                        dir_d  = step_down;
                        if (step_val == endv_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                endcase
            end
        end

        case (wr_idx)
            R_PERIOD: rddata_d = period_q;
            R_START:  rddata_d = start_q;
            R_END:    rddata_d = endv_q;
            R_STEP:   rddata_d = step_q;
            R_HOLD:   rddata_d = {{(DW-HOLD_W){1'b0}}, hold_q};
            R_STATUS: rddata_d = {{(DW-3){1'b0}}, dir_q, done_q, (state_q == S_RUN)};
            R_CUR:    rddata_d = duty_q;
            default:  rddata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            period_q <= '0;
            start_q  <= '0;
            endv_q   <= '0;
            step_q   <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= '0;
            duty_q   <= '0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            back_q   <= 1'b0;
            rddata_q <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            start_q  <= start_d;
            endv_q   <= endv_d;
            step_q   <= step_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            duty_q   <= duty_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            back_q   <= back_d;
            rddata_q <= rddata_d;
        end
    end

    assign period = period_q;
    assign duty   = duty_q;
    assign busy   = (state_q == S_RUN);
    assign rddata = rddata_q;

`ifdef PWM_SEQ_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;

    always_comb begin
        irq_en_d = irq_en_q;
        if (write && (wr_idx == R_CUR)) irq_en_d = wrdata[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= done_d & irq_en_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: directed scenarios plus randomized ramps against a sequence-list reference model.
module tb_pwm_ramp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  addr;
    logic        write;
    logic [31:0] wrdata, rddata, period, duty;
    logic        co, busy, irq;

    int checks = 0;
    int failures = 0;

    pwm_ramp_sequencer dut (
        .clk(clk), .rst(rst), .addr(addr), .write(write), .wrdata(wrdata),
        .rddata(rddata), .co(co), .period(period), .duty(duty), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: a ramp is the list of duty values visited, walked one entry per advance.
    logic [31:0] m_period, m_start, m_end, m_step, m_duty;
    logic [15:0] m_hold;
    longint      m_seq[$];
    int          m_idx, m_cnt, m_fwd_len;
    logic [1:0]  m_mode;
    logic        m_busy, m_done, m_dir, m_en;

    function automatic void model_reset();
        m_period = 0; m_start = 0; m_end = 0; m_step = 0; m_duty = 0; m_hold = 0;
        m_seq.delete(); m_idx = 0; m_cnt = 0; m_fwd_len = 0; m_mode = 0;
        m_busy = 0; m_done = 0; m_dir = 0; m_en = 0;
    endfunction

    function automatic void push_ramp(longint a, longint b, longint st, int drop_first, int drop_last);
        longint v = a;
        longint vals[$];
        vals.push_back(v);
        while (v != b) begin
            if (a < b) v = (v + st > b) ? b : v + st;
            else       v = (v - st < b) ? b : v - st;
            vals.push_back(v);
        end
        for (int i = drop_first; i < vals.size() - drop_last; i++) m_seq.push_back(vals[i]);
    endfunction

    function automatic void model_go(logic [1:0] md);
        m_dir = (m_start > m_end);
        if (m_step == 0 || m_start == m_end) begin
            m_duty = m_end; m_done = 1; m_busy = 0;
        end else begin
            m_seq.delete();
            push_ramp(longint'(m_start), longint'(m_end), longint'(m_step), 0, 0);
            m_fwd_len = m_seq.size();
            if (md == 2'd2) push_ramp(longint'(m_end), longint'(m_start), longint'(m_step), 1, 1);
            m_idx = 0; m_duty = 32'(m_seq[0]); m_busy = 1; m_done = 0; m_cnt = 0; m_mode = md;
        end
    endfunction

    function automatic void model_edge(logic c);
        logic [2:0] idx = addr[4:2];
        logic ctrl = write && (idx == 3'd5);
        logic sd = (m_start > m_end);
        if (write) begin
            case (idx)
                3'd0: m_period = wrdata;
                3'd1: m_start  = wrdata;
                3'd2: m_end    = wrdata;
                3'd3: m_step   = wrdata;
                3'd4: m_hold   = wrdata[15:0];
                3'd5: if (wrdata[1]) m_busy = 0; else if (wrdata[0]) model_go(wrdata[3:2]);
                3'd6: if (wrdata[1]) m_done = 0;
                default: m_en = wrdata[0];
            endcase
        end
        if (!ctrl && c && m_busy) begin
            if (m_cnt != int'(m_hold)) begin
                m_cnt++;
            end else begin
                m_cnt = 0;
                if (m_mode == 2'd1 || m_mode == 2'd2) begin
                    m_idx  = (m_idx + 1) % m_seq.size();
                    m_duty = 32'(m_seq[m_idx]);
                    if (m_mode == 2'd2) m_dir = (m_idx >= 1 && m_idx < m_fwd_len) ? sd : !sd;
                end else begin
                    m_idx++;
                    m_duty = 32'(m_seq[m_idx]);
                    if (m_idx == m_seq.size() - 1) begin m_busy = 0; m_done = 1; end
                end
            end
        end
    endfunction

    function automatic logic exp_irq();
`ifdef PWM_SEQ_IRQ_EN
        return m_done & m_en;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_regval(int idx);
        case (idx)
            0: return m_period;
            1: return m_start;
            2: return m_end;
            3: return m_step;
            4: return {16'd0, m_hold};
            6: return {29'd0, m_dir, m_done, m_busy};
            7: return m_duty;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(logic c);
        co = c;
        @(posedge clk);
        model_edge(c);
        @(negedge clk);
        co = 1'b0;
        chk("duty", duty, m_duty);
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("period", period, m_period);
        chk("irq", {31'd0, irq}, {31'd0, exp_irq()});
    endtask

    task automatic wr(int idx, logic [31:0] d, logic c);
        addr = {3'(idx), 2'b00}; write = 1'b1; wrdata = d;
        tick(c);
        write = 1'b0;
    endtask

    task automatic rd(int idx, string tag);
        logic [31:0] exp;
        addr = {3'(idx), 2'b00}; write = 1'b0;
        exp = m_regval(idx);
        tick(1'b0);
        chk(tag, rddata, exp);
    endtask

    initial begin
        rst = 1'b1; addr = '0; write = 1'b0; wrdata = '0; co = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_period", period, 32'd0);
        chk("rst_duty", duty, 32'd0);
        chk("rst_rddata", rddata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rd(0, "rd_period_rst");

        // One-shot up, HOLD=1: a step every second co.
        wr(0, 32'd100, 0); wr(1, 32'd10, 0); wr(2, 32'd50, 0); wr(3, 32'd10, 0); wr(4, 32'd1, 0);
        wr(5, 32'h1, 0);
        chk("t1_first", duty, 32'd10);
        repeat (12) tick(1'b1);
        chk("t1_final", duty, 32'd50);
        rd(6, "t1_status");
        chk("t1_status_val", rddata, 32'h2);
        rd(4, "t1_hold");

        // One-shot down with clamped underflow.
        wr(1, 32'd50, 0); wr(2, 32'd5, 0); wr(3, 32'd20, 0); wr(4, 32'd0, 0);
        wr(5, 32'h1, 0);
        repeat (5) tick(1'b1);
        chk("t2_final", duty, 32'd5);
        rd(6, "t2_status");
        chk("t2_status_val", rddata, 32'h6);

        // Triangle, then stop holds the value.
        wr(1, 32'd0, 0); wr(2, 32'd30, 0); wr(3, 32'd15, 0);
        wr(5, 32'h9, 0);
        repeat (10) tick(1'b1);
        chk("t3_peak", duty, 32'd30);
        wr(5, 32'h2, 0);
        repeat (4) tick(1'b1);
        chk("t3_held", duty, 32'd30);

        // Degenerate STEP=0.
        wr(3, 32'd0, 0);
        wr(5, 32'h1, 0);
        chk("t4_duty", duty, 32'd30);
        rd(6, "t4_status");

        // go with co in the same cycle: co ignored.
        wr(1, 32'd7, 0); wr(2, 32'd40, 0); wr(3, 32'd3, 0); wr(4, 32'd0, 0);
        wr(7, 32'h1, 0);
        wr(5, 32'h1, 1);
        chk("t5_co_ignored", duty, 32'd7);
        repeat (15) tick(1'b1);
        rd(6, "t5_status");
        wr(6, 32'h2, 0);
        rd(7, "t5_cur");

        // Top-of-range ramp must clamp, not wrap.
        wr(1, 32'hFFFF_FF00, 0); wr(2, 32'hFFFF_FFF0, 0); wr(3, 32'h80, 0);
        wr(5, 32'h1, 0);
        repeat (3) tick(1'b1);
        chk("t6_clamp", duty, 32'hFFFF_FFF0);

        // Loop mode directed.
        wr(1, 32'd10, 0); wr(2, 32'd30, 0); wr(3, 32'd10, 0);
        wr(5, 32'h5, 0);
        repeat (4) tick(1'b1);
        chk("t7_wrap", duty, 32'd20);

        for (int it = 0; it < 24; it++) begin
            logic [1:0] md;
            md = 2'($urandom_range(0, 3));
            wr(1, 32'($urandom_range(0, 200)), 0);
            wr(2, 32'($urandom_range(0, 200)), 0);
            wr(3, 32'($urandom_range(0, 45)), 0);
            wr(4, 32'($urandom_range(0, 3)), 0);
            wr(5, {28'd0, md, 2'b01}, 0);
            repeat ($urandom_range(10, 40)) tick(1'($urandom_range(0, 1)));
            rd(6, "rand_status");
            rd(7, "rand_cur");
            if ($urandom_range(0, 1) == 1) wr(5, 32'h2, 0);
        end

        // Async reset mid-ramp.
        wr(0, 32'd77, 0); wr(1, 32'd0, 0); wr(2, 32'd100, 0); wr(3, 32'd1, 0); wr(4, 32'd0, 0);
        wr(5, 32'h1, 0);
        repeat (5) tick(1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_duty", duty, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_period", period, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1);
        rd(1, "arst_start");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
